// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: MSB-nibble-first wide magnitude compare time-sharing one cmp_four slice.
// Define CMP_SEQ_SIGNED_EN for two's complement operands (sign-offset on the MSB slice).
module cmp_four (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       g,
    output logic       e,
    output logic       l
);
    assign g = a > b;
    assign e = a == b;
    assign l = a < b;
endmodule

module cmp_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 great,
    output logic                 equal,
    output logic                 less,
    output logic [4:0]           nib_cnt
);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [NIBBLES-1:0][3:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    great_q, great_d, equal_q, equal_d, less_q, less_d;
    logic [4:0]              nib_q, nib_d;
    logic [3:0]              sa, sb;
    logic                    sg, se, sl;

`ifdef CMP_SEQ_SIGNED_EN
    // Inverting the sign bit maps two's complement onto offset binary for the top slice.
    logic flip;
    assign flip = idx_q == LAST;
    assign sa   = a_q[idx_q] ^ {flip, 3'b000};
    assign sb   = b_q[idx_q] ^ {flip, 3'b000};
`else
    assign sa = a_q[idx_q];
    assign sb = b_q[idx_q];
`endif

    cmp_four u_cmp (.a(sa), .b(sb), .g(sg), .e(se), .l(sl));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        great_d = great_q;
        equal_d = equal_q;
        less_d  = less_q;
        nib_d   = nib_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                a_d     = a;
                b_d     = b;
                idx_d   = LAST;
                great_d = 1'b0;
                equal_d = 1'b0;
                less_d  = 1'b0;
                nib_d   = 5'd0;
                busy_d  = 1'b1;
            end
            RUN: begin
                nib_d   = nib_q + 5'd1;
                great_d = sg;
                less_d  = sl;
                equal_d = se && idx_q == '0;
                if (sg || sl || idx_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d  = idx_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            great_q <= 1'b0;
            equal_q <= 1'b0;
            less_q  <= 1'b0;
            nib_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            great_q <= great_d;
            equal_q <= equal_d;
            less_q  <= less_d;
            nib_q   <= nib_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign great   = great_q;
    assign equal   = equal_q;
    assign less    = less_q;
    assign nib_cnt = nib_q;
endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// tb_cmp_seq_ctrl: randomized and directed checks of cmp_seq_ctrl against a timeline model.
module tb_cmp_seq_ctrl;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [4*N-1:0] a = '0, b = '0;
    logic busy, done, great, equal, less;
    logic [4:0] nib_cnt;
    int n_checks = 0, n_fail = 0;
    bit chk_en = 1'b0;

    cmp_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .great(great), .equal(equal), .less(less),
        .nib_cnt(nib_cnt)
    );

    always #5 clk = ~clk;

    // Reference: k = nibbles up to and including the first differing one; result from whole-word compare.
    task automatic ref_cmp(input logic [4*N-1:0] x, input logic [4*N-1:0] y,
                           output int k, output logic g, output logic e, output logic l);
        k = N;
        for (int i = N - 1; i >= 0; i--)
            if (((x >> (4 * i)) & 'hF) != ((y >> (4 * i)) & 'hF)) begin
                k = N - i;
                break;
            end
`ifdef CMP_SEQ_SIGNED_EN
        g = $signed(x) > $signed(y);
        l = $signed(x) < $signed(y);
`else
        g = x > y;
        l = x < y;
`endif
        e = x == y;
    endtask

    bit act = 1'b0, have = 1'b0;
    int rel = 0, mk = 0;
    logic mg = 1'b0, me = 1'b0, ml = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            act = 1'b0;
            have = 1'b0;
            rel = 0;
            mk = 0;
        end else if (!act && start) begin
            ref_cmp(a, b, mk, mg, me, ml);
            act = 1'b1;
            have = 1'b1;
            rel = 0;
        end else if (act) begin
            rel++;
            if (rel > mk) act = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic e_busy, e_done;
        logic [2:0] e_res;
        logic [4:0] e_nib;
        if (chk_en) begin
            e_busy = act && rel < mk;
            e_done = act && rel == mk;
            e_nib  = 5'(act ? rel : (have ? mk : 0));
            e_res  = (have && !e_busy) ? {mg, me, ml} : 3'b000;
            n_checks++;
            if ({busy, done, great, equal, less, nib_cnt} != {e_busy, e_done, e_res, e_nib}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got busy=%b done=%b gel=%b%b%b nib=%0d exp busy=%b done=%b gel=%b nib=%0d",
                         $time, busy, done, great, equal, less, nib_cnt, e_busy, e_done, e_res, e_nib);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Drives one start from IDLE and returns cycles-to-done counted from the driving negedge.
    task automatic run_one(input logic [4*N-1:0] x, input logic [4*N-1:0] y, output int n);
        start = 1'b1;
        a = x;
        b = y;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!done && n < 40);
        if (n >= 40) check("done_timeout", 0, 1);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("reset_outs", {busy, done, great, equal, less, nib_cnt}, 0);

        run_one(16'h1234, 16'h1334, n);
        check("lt_latency", n, 3);
        check("lt_gel", {great, equal, less}, 3'b001);
        check("lt_nib", nib_cnt, 2);
        @(negedge clk);

        run_one(16'hBEEF, 16'hBEEF, n);
        check("eq_latency", n, 5);
        check("eq_gel", {great, equal, less}, 3'b010);
        check("eq_nib", nib_cnt, 4);
        @(negedge clk);
        check("hold_gel", {done, great, equal, less, nib_cnt}, {4'b0010, 5'd4});

        run_one(16'h9000, 16'h8FFF, n);
        check("gt_latency", n, 2);
        check("gt_gel", {great, equal, less}, 3'b100);
        check("gt_nib", nib_cnt, 1);
        @(negedge clk);

        run_one(16'h8000, 16'h0001, n);
`ifdef CMP_SEQ_SIGNED_EN
        check("sign_gel", {great, equal, less}, 3'b001);
`else
        check("sign_gel", {great, equal, less}, 3'b100);
`endif
        check("sign_nib", nib_cnt, 1);
        @(negedge clk);

        // start held high with operands changing during RUN
        start = 1'b1;
        a = 16'h1234;
        b = 16'h1334;
        n = 0;
        do begin
            @(negedge clk);
            a = 16'(($urandom));
            b = 16'(($urandom));
            n++;
        end while (!done && n < 40);
        check("held_latency", n, 3);
        check("held_gel", {great, equal, less, nib_cnt}, {3'b001, 5'd2});
        @(negedge clk);
        check("held_idle_gap", busy, 0);
        @(negedge clk);
        check("held_reaccept", busy, 1);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("held_timeout", 0, 1);
        repeat (2) @(negedge clk);

        // reset while idx==2
        start = 1'b1;
        a = 16'hBEEF;
        b = 16'hBEEF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_outs", {busy, done, great, equal, less, nib_cnt}, 0);
        repeat (4) @(negedge clk);
        check("rst_no_done", {busy, done}, 0);
        run_one(16'h9000, 16'h8FFF, n);
        check("post_rst_latency", n, 2);
        check("post_rst_gel", {great, equal, less}, 3'b100);
        @(negedge clk);

        for (int i = 0; i < 3000; i++) begin
            int mode;
            start = $urandom_range(0, 2) == 0;
            rst_n = $urandom_range(0, 249) != 0;
            if ($urandom_range(0, 1) == 1) begin
                mode = $urandom_range(0, 2);
                a = 16'($urandom);
                b = mode == 0 ? 16'($urandom) : a;
                if (mode == 2) b = b ^ (16'(1) << $urandom_range(0, 15));
            end
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cmp_seq_ctrl.md
Name: cmp_seq_ctrl

Overview:
- Sequential wide-operand magnitude comparator controller.
- Compares two NIBBLES*4-bit operands MSB-nibble-first, time-sharing exactly one instance of the team's 4-bit comparator `cmp_four`.
- Stops early on the first unequal nibble.
- Used wherever a wide compare is needed but comparator area must stay at one 4-bit slice; start/busy/done handshake toward the requesting FSM.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a compare; sampled only in IDLE.
- a  in  W  operand A; sampled on accepted start.
- b  in  W  operand B; sampled on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the result is valid.
- great  out  1  registered result A>B.
- equal  out  1  registered result A==B.
- less  out  1  registered result A<B.
- nib_cnt  out  5  number of nibbles examined for the last result, 1..NIBBLES.

Behaviour:
- Reset and synchronicity:
  - Reset is synchronous, active-low. rst_n low at a clock edge forces state IDLE.
  - Reset values: busy=0, done=0, great=0, equal=0, less=0, nib_cnt=0, idx=0, operand registers=0.
  - Reset mid-RUN aborts the compare; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a and b into internal registers, set idx=NIBBLES-1, clear great/equal/less/nib_cnt to 0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1):
  - The single `cmp_four` sees latched_a[4*idx+3:4*idx] and latched_b[4*idx+3:4*idx] combinationally.
  - At each edge, nib_cnt is incremented.
  - Slice g=1: great<=1, go to DONE.
  - Slice l=1: less<=1, go to DONE.
  - Slice e=1 and idx==0: equal<=1, go to DONE.
  - Slice e=1 and idx>0: idx<=idx-1, stay in RUN.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then unconditional return to IDLE.
  - start is ignored while in DONE.
- Handshake and result holding:
  - start is ignored in RUN and DONE; no queuing.
  - Input operand changes after acceptance have no effect.
  - Results and nib_cnt hold their values from DONE until the next accepted start clears them.
  - Exactly one of great/equal/less is 1 from DONE until the next accepted start.
- Latency:
  - Start accepted at edge t; done is high during cycle t+k+1, where k = nibbles examined (1..NIBBLES).
  - Worst case (equal operands): NIBBLES+1 cycles.
  - Back-to-back: the next start may be accepted at the edge ending the IDLE cycle that follows DONE.
- Width rules:
  - idx width is max(1, $clog2(NIBBLES)).
  - nib_cnt is zero-extended to 5 bits.
- NIBBLES=1: RUN lasts one cycle and always terminates.

Optional Feature:
- Macro: CMP_SEQ_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - Bit 3 of both nibbles is inverted before feeding the comparator, only when idx==NIBBLES-1 (the MSB slice). This is the sign-offset trick.
  - All other slices compare unsigned.
  - Latency is unchanged.
- Undefined: pure unsigned compare; no inversion logic is present.

Test Plan:
- NIBBLES=4, a=16'h1234, b=16'h1334, start at cycle 0 -> busy cycles 1-2; done at cycle 3; less=1, great=0, equal=0, nib_cnt=2.
- a=b=16'hBEEF -> busy cycles 1-4; done at cycle 5; equal=1, nib_cnt=4.
- a=16'h9000, b=16'h8FFF -> done at cycle 2; great=1, nib_cnt=1.
- start held high continuously, plus a and b changed during RUN -> result reflects the originally latched operands; a second compare is accepted only after the IDLE cycle following DONE.
- rst_n=0 for one cycle during RUN idx=2 -> next cycle IDLE, all outputs 0, no done pulse; a fresh start then completes normally.
- With CMP_SEQ_SIGNED_EN: a=16'h8000, b=16'h0001 -> less=1, nib_cnt=1. Without the macro, the same operands -> great=1, nib_cnt=1.
